ex_lsu: RTL and testbench
=========================

# ex_lsu

Multi-cycle load/store unit for the execute stage, replacing the single-cycle, always-ready memory access path with a request/acknowledge handshake to a RAM that may insert wait states. It supports byte, halfword and word loads and stores with byte enables and sign/zero extension, and flags misaligned and timed-out accesses. It holds the pipeline through `busy_o` while an access is outstanding, and returns the writeback data and register index as a one-cycle response.

## Interface
- `ADDR_W`, 32, memory address width; the effective address is truncated to this width.
- `TIMEOUT`, 16, maximum number of ACCESS cycles without `mem_ack_i` before a bus error; 0 disables the timeout.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_valid_i`  in  1  access request.
- `req_ready_o`  out  1  unit can accept a request; equals (state==IDLE) & ~rst.
- `req_op_i`  in  3  LSU op code (package `LSU_*`).
- `req_base_i`  in  32  base register value.
- `req_offset_i`  in  16  immediate; sign-extended.
- `req_wdata_i`  in  32  store data; only low byte/half/word used.
- `req_wreg_i`  in  5  destination register for loads.
- `resp_valid_o`  out  1  one-cycle response pulse.
- `resp_we_o`  out  1  register write enable; 1 only for a load without error.
- `resp_wreg_o`  out  5  destination register, echoed from the request.
- `resp_wdata_o`  out  32  extended load data; 0 for stores and errors.
- `resp_err_o`  out  2  00 ok, 01 misaligned, 10 timeout.
- `busy_o`  out  1  state != IDLE; pipeline stall.
- `mem_cs_o`  out  1  memory select.
- `mem_we_o`  out  1  1 = write.
- `mem_addr_o`  out  ADDR_W  word-aligned address; low two bits are 0.
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  32  lane-replicated store data.
- `mem_rdata_i`  in  32  read data; valid in the `mem_ack_i` cycle.
- `mem_ack_i`  in  1  access complete.

## Operation
- **Ops:** LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
- **Effective address:** EA = req_base_i + sext(req_offset_i), computed mod 2^32.
- **Byte order:** little-endian; EA[1:0]=0 selects bits 7:0.
- **Alignment:** halfword ops need EA[0]=0; word ops need EA[1:0]=0. Byte ops are never misaligned.
- **Byte enables:**
  - byte: 4'b0001 << EA[1:0].
  - half: 4'b0011 << EA[1:0].
  - word: 4'b1111.
- **Store data:** byte replicated ×4, half replicated ×2, word as-is.
- **Load extraction:** select the lane given by EA[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- **FSM states:** IDLE, ACCESS, RESP.
  - **IDLE:** when req_valid_i & req_ready_o, latch op, EA, wdata and wreg.
    - Misaligned: go to RESP with err=01. mem_cs_o never asserts.
    - Aligned: go to ACCESS.
  - **ACCESS:** mem_cs_o=1. mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are registered and stay stable for the whole state.
    - mem_ack_i=1: capture the extracted load data, go to RESP with err=00.
    - Otherwise the wait counter increments. When the counter reaches TIMEOUT (TIMEOUT≠0), go to RESP with err=10.
    - An ack arriving in the same cycle as the counter reaching TIMEOUT wins: the access is reported ok.
  - **RESP:** resp_valid_o=1 for exactly one cycle, then IDLE.
    - The response has no backpressure.
    - Stores report resp_we_o=0 and resp_wdata_o=0.
- **Requests while busy:** requests presented outside IDLE are not accepted. The requester holds its inputs until req_ready_o is high.
- **Reset values:** all outputs 0, state IDLE, wait counter 0.
- **Reset mid-ACCESS:** mem_cs_o drops at the next edge and no response is issued.

## Timing
- mem_* outputs and resp_* outputs are registered. req_ready_o and busy_o are decoded from state.
- Accept at edge N → mem_cs_o high in cycle N+1.
- Ack sampled at edge M → resp_valid_o high in cycle M+1.
- Zero-wait memory: response two cycles after acceptance, giving a throughput of one access per 3 cycles.
- Misaligned request: resp_valid_o in cycle N+1, with no memory cycle.
- Timeout: at most TIMEOUT ACCESS cycles, then RESP.
- Wait counter width is $clog2(TIMEOUT+1).

## Structure
- **Package `lsu_pkg`:** `LSU_*` op codes, the lsu_op_t and lsu_err_t typedefs, and the FSM state enum.
- **Sub-module `lsu_lane`:** purely combinational.
  - Takes op, EA[1:0], store data and read data.
  - Produces be, replicated store data, extended load data and the misaligned flag.
- The top level holds the FSM, the request latches and the wait counter.

## Test plan
- LW, base 0x100, offset 0x4, memory acks after 0 waits with rdata 0xDEADBEEF → mem_addr 0x104, be 4'b1111; resp_valid 2 cycles after accept, wdata 0xDEADBEEF, we=1, err=00.
- LB/LBU at EA 0x103, rdata 0x80112233 → LB gives 0xFFFFFF80, LBU gives 0x00000080; be 4'b1000.
- SH at EA 0x202, wdata 0x0000ABCD → mem_we=1, be 4'b1100, mem_wdata 0xABCDABCD; resp we=0.
- LW at EA 0x101 → err=01, we=0, mem_cs_o never asserted; resp_valid in cycle N+1.
- TIMEOUT=4 with ack never asserted → exactly 4 ACCESS cycles, then err=10 and mem_cs_o low. A second run with the ack in the 4th wait cycle gives err=00.
- rst asserted during a 3-wait-state access → mem_cs_o low next cycle, no resp_valid, req_ready_o=1 after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op codes, error codes and FSM states for the load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LBU = 3'd1,
    LSU_LH  = 3'd2,
    LSU_LHU = 3'd3,
    LSU_LW  = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    LSU_ERR_OK       = 2'b00,
    LSU_ERR_MISALIGN = 2'b01,
    LSU_ERR_TIMEOUT  = 2'b10
  } lsu_err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_t;

  function automatic logic lsu_is_store(lsu_op_t op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane steering: enables, store replication, load extension, alignment
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  lsu_op_t     op_e;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign op_e      = lsu_op_t'(op);
  assign byte_lane = rdata[{ea_lo, 3'b000} +: 8];
  assign half_lane = ea_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b0000;
    st_data    = 32'h0;
    ld_data    = 32'h0;
    misaligned = 1'b0;
    case (op_e)
      LSU_LB, LSU_LBU, LSU_SB: begin
        be      = 4'b0001 << ea_lo;
        st_data = {4{wdata[7:0]}};
        ld_data = (op_e == LSU_LB) ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      end
      LSU_LH, LSU_LHU, LSU_SH: begin
        misaligned = ea_lo[0];
        be         = 4'b0011 << ea_lo;
        st_data    = {2{wdata[15:0]}};
        ld_data    = (op_e == LSU_LH) ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      end
      default: begin
        misaligned = |ea_lo;
        be         = 4'b1111;
        st_data    = wdata;
        ld_data    = rdata;
      end
    endcase
  end

endmodule

// File: rtl/ex_lsu.sv
// rtl/ex_lsu.sv - multi-cycle load/store unit with wait-state tolerant memory handshake
module ex_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [31:0]       req_base_i,
  input  logic [15:0]       req_offset_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_wreg_i,
  output logic              resp_valid_o,
  output logic              resp_we_o,
  output logic [4:0]        resp_wreg_o,
  output logic [31:0]       resp_wdata_o,
  output logic [1:0]        resp_err_o,
  output logic              busy_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t       state, state_nxt;
  lsu_op_t          op_q;
  logic [1:0]       ea_lo_q;
  logic [4:0]       wreg_q;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0] ea;
  logic        accept;
  logic        timeout_hit;
  lsu_op_t     lane_op;
  logic [1:0]  lane_ea_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_st_data;
  logic [31:0] lane_ld_data;
  logic        lane_misaligned;

  assign ea          = req_base_i + {{16{req_offset_i[15]}}, req_offset_i};
  assign req_ready_o = (state == ST_IDLE) & ~rst;
  assign busy_o      = (state != ST_IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign timeout_hit = (TIMEOUT != 0) &&
                       (({1'b0, wait_cnt} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(TIMEOUT));

  // One lane decoder serves both phases: request fields while idle, latched op during the access.
  assign lane_op    = (state == ST_IDLE) ? lsu_op_t'(req_op_i) : op_q;
  assign lane_ea_lo = (state == ST_IDLE) ? ea[1:0] : ea_lo_q;

  lsu_lane u_lane (
    .op         (lane_op),
    .ea_lo      (lane_ea_lo),
    .wdata      (req_wdata_i),
    .rdata      (mem_rdata_i),
    .be         (lane_be),
    .st_data    (lane_st_data),
    .ld_data    (lane_ld_data),
    .misaligned (lane_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = lane_misaligned ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (mem_ack_i || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= LSU_LB;
      ea_lo_q      <= 2'b00;
      wreg_q       <= 5'd0;
      wait_cnt     <= '0;
      resp_valid_o <= 1'b0;
      resp_we_o    <= 1'b0;
      resp_wreg_o  <= 5'd0;
      resp_wdata_o <= 32'h0;
      resp_err_o   <= 2'b00;
      mem_cs_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= 4'b0000;
      mem_wdata_o  <= 32'h0;
    end else begin
      // Response fields only carry meaning during the pulse.
      resp_valid_o <= 1'b0;
      resp_we_o    <= 1'b0;
      resp_wreg_o  <= 5'd0;
      resp_wdata_o <= 32'h0;
      resp_err_o   <= LSU_ERR_OK;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= lsu_op_t'(req_op_i);
            ea_lo_q  <= ea[1:0];
            wreg_q   <= req_wreg_i;
            wait_cnt <= '0;
            if (lane_misaligned) begin
              resp_valid_o <= 1'b1;
              resp_wreg_o  <= req_wreg_i;
              resp_err_o   <= LSU_ERR_MISALIGN;
            end else begin
              mem_cs_o    <= 1'b1;
              mem_we_o    <= lsu_is_store(lsu_op_t'(req_op_i));
              mem_addr_o  <= {ea[ADDR_W-1:2], 2'b00};
              mem_be_o    <= lane_be;
              mem_wdata_o <= lane_st_data;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack_i) begin
            mem_cs_o     <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_wreg_o  <= wreg_q;
            resp_we_o    <= ~lsu_is_store(op_q);
            resp_wdata_o <= lsu_is_store(op_q) ? 32'h0 : lane_ld_data;
          end else if (timeout_hit) begin
            mem_cs_o     <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_wreg_o  <= wreg_q;
            resp_err_o   <= LSU_ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_lsu.sv
// tb/tb_ex_lsu.sv - vector table, reset-abort sequence and randomized runs against a reference model
module tb_ex_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_base_i;
  logic [15:0] req_offset_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_wreg_i;
  logic        resp_valid_o;
  logic        resp_we_o;
  logic [4:0]  resp_wreg_o;
  logic [31:0] resp_wdata_o;
  logic [1:0]  resp_err_o;
  logic        busy_o;
  logic        mem_cs_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_base_i(req_base_i), .req_offset_i(req_offset_i), .req_wdata_i(req_wdata_i),
    .req_wreg_i(req_wreg_i),
    .resp_valid_o(resp_valid_o), .resp_we_o(resp_we_o), .resp_wreg_o(resp_wreg_o),
    .resp_wdata_o(resp_wdata_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    int          nwait;   // ACCESS cycles before ack; negative = never
    logic [31:0] rdata;
    logic [1:0]  e_err;
    logic        e_we;
    logic [31:0] e_wdata;
    int          e_lat;   // cycles from accept edge to the response cycle
    int          e_cs;    // number of cycles mem_cs_o is high
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_mwdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [31:0] ea, mask, ext;
    int          size, lo;
    bit          store, sgn;
    r     = v;
    ea    = v.base + {{16{v.off[15]}}, v.off};
    size  = (v.op == 0 || v.op == 1 || v.op == 5) ? 1 : (v.op == 2 || v.op == 3 || v.op == 6) ? 2 : 4;
    store = (v.op >= 5);
    sgn   = (v.op == 0 || v.op == 2);
    lo    = int'(ea % 4);
    mask  = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    ext   = (v.rdata >> (8 * lo)) & mask;
    if (sgn && ext[8*size-1]) ext = ext | ~mask;
    r.e_addr   = ea & ~32'h3;
    r.e_be     = 4'(((1 << size) - 1) << lo);
    r.e_mwdata = (size == 1) ? v.wdata[7:0] * 32'h0101_0101 :
                 (size == 2) ? v.wdata[15:0] * 32'h0001_0001 : v.wdata;
    if ((ea % size) != 0) begin
      r.e_err = 2'd1; r.e_we = 0; r.e_wdata = 0; r.e_lat = 1; r.e_cs = 0;
    end else if (v.nwait < 0 || v.nwait >= TO) begin
      r.e_err = 2'd2; r.e_we = 0; r.e_wdata = 0; r.e_lat = TO + 1; r.e_cs = TO;
    end else begin
      r.e_err = 2'd0; r.e_we = !store; r.e_wdata = store ? 32'h0 : ext;
      r.e_lat = v.nwait + 2; r.e_cs = v.nwait + 1;
    end
    return r;
  endfunction

  // Issue one request, play the memory, hold junk on the request port while busy.
  task automatic run(input vec_t v, input string tag);
    int          cs_n, lat, guard;
    bit          got_v, stable;
    logic [31:0] a0, d0, r_wd;
    logic [3:0]  b0;
    logic        w0, r_we;
    logic [1:0]  r_err;
    logic [4:0]  r_wreg;
    guard = 0;
    while (!req_ready_o && guard < 20) begin @(negedge clk); guard++; end
    chk({tag, " ready"}, req_ready_o, 1);
    req_valid_i = 1; req_op_i = v.op; req_base_i = v.base; req_offset_i = v.off;
    req_wdata_i = v.wdata; req_wreg_i = v.wreg;
    cs_n = 0; lat = 0; got_v = 0; stable = 1;
    a0 = 0; d0 = 0; b0 = 0; w0 = 0; r_wd = 0; r_we = 0; r_err = 0; r_wreg = 0;
    for (int cyc = 1; cyc <= 40 && !got_v; cyc++) begin
      @(negedge clk);
      req_op_i = 3'($urandom); req_base_i = $urandom; req_offset_i = 16'($urandom);
      req_wdata_i = $urandom; req_wreg_i = 5'($urandom);
      if (cyc == 1) chk({tag, " busy"}, busy_o, 1);
      mem_ack_i = 0;
      mem_rdata_i = $urandom;
      if (mem_cs_o) begin
        if (cs_n == 0) begin
          a0 = mem_addr_o; b0 = mem_be_o; w0 = mem_we_o; d0 = mem_wdata_o;
        end else if (a0 !== mem_addr_o || b0 !== mem_be_o || w0 !== mem_we_o || d0 !== mem_wdata_o) begin
          stable = 0;
        end
        if (v.nwait >= 0 && cs_n == v.nwait) begin
          mem_ack_i = 1; mem_rdata_i = v.rdata;
        end
        cs_n++;
      end
      if (resp_valid_o) begin
        got_v = 1; lat = cyc;
        r_we = resp_we_o; r_wd = resp_wdata_o; r_err = resp_err_o; r_wreg = resp_wreg_o;
        req_valid_i = 0;
      end
    end
    mem_ack_i = 0; req_valid_i = 0;
    chk({tag, " resp_seen"}, 32'(got_v), 1);
    chk({tag, " err"}, r_err, v.e_err);
    chk({tag, " we"}, r_we, v.e_we);
    chk({tag, " wdata"}, r_wd, v.e_wdata);
    chk({tag, " wreg"}, r_wreg, v.wreg);
    chk({tag, " latency"}, lat, v.e_lat);
    chk({tag, " cs_cycles"}, cs_n, v.e_cs);
    if (v.e_cs > 0) begin
      chk({tag, " addr"}, a0, v.e_addr);
      chk({tag, " be"}, b0, v.e_be);
      chk({tag, " mem_we"}, w0, v.op >= 5);
      chk({tag, " mem_wdata"}, d0, v.e_mwdata);
      chk({tag, " stable"}, 32'(stable), 1);
    end
    @(negedge clk);
    chk({tag, " pulse_end"}, resp_valid_o, 0);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    //          op base          off      wdata         wreg nwait rdata         err we wdata         lat cs addr          be       mwdata
    tbl[0] = '{3'd4, 32'h100, 16'h0004, 32'h0,        5'd1, 0,  32'hDEADBEEF, 2'd0, 1, 32'hDEADBEEF, 2, 1, 32'h104, 4'b1111, 32'h0};
    tbl[1] = '{3'd0, 32'h100, 16'h0003, 32'h0,        5'd2, 0,  32'h80112233, 2'd0, 1, 32'hFFFFFF80, 2, 1, 32'h100, 4'b1000, 32'h0};
    tbl[2] = '{3'd1, 32'h100, 16'h0003, 32'h0,        5'd3, 1,  32'h80112233, 2'd0, 1, 32'h00000080, 3, 2, 32'h100, 4'b1000, 32'h0};
    tbl[3] = '{3'd6, 32'h200, 16'h0002, 32'h0000ABCD, 5'd4, 0,  32'h12345678, 2'd0, 0, 32'h0,        2, 1, 32'h200, 4'b1100, 32'hABCDABCD};
    tbl[4] = '{3'd4, 32'h100, 16'h0001, 32'h0,        5'd5, 0,  32'h0,        2'd1, 0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0};
    tbl[5] = '{3'd4, 32'h400, 16'h0000, 32'h0,        5'd6, -1, 32'h0,        2'd2, 0, 32'h0,        5, 4, 32'h400, 4'b1111, 32'h0};
    tbl[6] = '{3'd4, 32'h400, 16'h0008, 32'h0,        5'd7, 3,  32'hCAFEF00D, 2'd0, 1, 32'hCAFEF00D, 5, 4, 32'h408, 4'b1111, 32'h0};
    tbl[7] = '{3'd2, 32'h1000,16'hFFFE, 32'h0,        5'd8, 2,  32'h80017FFF, 2'd0, 1, 32'hFFFF8001, 4, 3, 32'hFFC, 4'b1100, 32'h0};
    tbl[8] = '{3'd5, 32'h0,   16'h0007, 32'h0000005A, 5'd9, 0,  32'h0,        2'd0, 0, 32'h0,        2, 1, 32'h4,   4'b1000, 32'h5A5A5A5A};

    rst = 1; req_valid_i = 0; req_op_i = 0; req_base_i = 0; req_offset_i = 0;
    req_wdata_i = 0; req_wreg_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
    @(negedge clk); @(negedge clk);
    chk("rst ready", req_ready_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst cs", mem_cs_o, 0);
    chk("rst resp_valid", resp_valid_o, 0);
    chk("rst resp_wdata", resp_wdata_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst ready", req_ready_o, 1);

    for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Reset during a waiting access: no response, memory released at once.
    req_valid_i = 1; req_op_i = 3'd4; req_base_i = 32'h300; req_offset_i = 0; req_wreg_i = 5'd11;
    @(negedge clk); req_valid_i = 0;
    chk("abort cs1", mem_cs_o, 1);
    @(negedge clk);
    chk("abort cs2", mem_cs_o, 1);
    rst = 1;
    @(negedge clk);
    chk("abort cs_drop", mem_cs_o, 0);
    chk("abort no_resp", resp_valid_o, 0);
    chk("abort ready_in_rst", req_ready_o, 0);
    rst = 0;
    @(negedge clk);
    chk("abort ready", req_ready_o, 1);
    chk("abort busy", busy_o, 0);
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (resp_valid_o || mem_cs_o) seen++;
        @(negedge clk);
      end
      chk("abort quiet", seen, 0);
    end

    for (int i = 0; i < 80; i++) begin
      rv = tbl[0];
      rv.op    = 3'($urandom);
      rv.base  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
      rv.off   = 16'($urandom);
      rv.wdata = $urandom;
      rv.wreg  = 5'($urandom);
      rv.nwait = $urandom_range(0, 5);
      rv.rdata = $urandom;
      rv = model(rv);
      run(rv, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
